// File: rtl/nco_seq_ctrl.sv
// NCO sequencer: edge-detects register-file control bits and drives phase clear,
// accumulator enable and a req/ack step-load handshake with a sticky timeout flag.
module nco_seq_ctrl #(
    parameter int ACK_TIMEOUT = 16,
    parameter int STEP_W      = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_start_i,
    input  logic              run_stop_i,
    input  logic              load_start_i,
    input  logic              load_ready_i,
    input  logic [STEP_W-1:0] freq_step_i,
    input  logic              nco_load_ack_i,
    output logic              nco_en_o,
    output logic              nco_phase_clr_o,
    output logic [STEP_W-1:0] nco_step_o,
    output logic              nco_load_req_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [2:0]        state_o
);

    // States: IDLE=0 stopped | CLR=1 phase clear | RUN=2 accumulating | LD_WAIT=3 await ready | LD_REQ=4 handshake
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLR     = 3'd1,
        S_RUN     = 3'd2,
        S_LD_WAIT = 3'd3,
        S_LD_REQ  = 3'd4
    } state_t;

    localparam int                CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(ACK_TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [3:0]          prev_q;
    logic [3:0]          rise;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ral_q, ral_d;
    logic                pend_q, pend_d;
    logic                err_q, err_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                en_q, en_d;
    logic                clr_q, clr_d;
    logic                req_q, req_d;
    logic                busy_q, busy_d;

    logic start_rise, stop_rise, load_rise, ready_rise;

    always_comb begin
        rise       = {load_ready_i, load_start_i, run_stop_i, run_start_i} & ~prev_q;
        start_rise = rise[0];
        stop_rise  = rise[1];
        load_rise  = rise[2];
        ready_rise = rise[3];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ral_d   = ral_q;
        pend_d  = pend_q;
        err_d   = err_q;
        step_d  = step_q;
        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d = S_CLR;
                end else if (load_rise) begin
                    state_d = S_LD_WAIT;
                    ral_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_CLR: state_d = S_RUN;
            S_RUN: begin
                if (stop_rise) begin
                    state_d = S_IDLE;
                end else if (load_rise) begin
                    state_d = S_LD_WAIT;
                    ral_d   = 1'b1;
                    err_d   = 1'b0;
                end
            end
            S_LD_WAIT: begin
                if (stop_rise) begin
                    state_d = S_IDLE;
                end else if (ready_rise) begin
                    state_d = S_LD_REQ;
                    step_d  = freq_step_i;
                    cnt_d   = CNT_LOAD;
                    pend_d  = 1'b0;
                end
            end
            S_LD_REQ: begin
                // A stop seen during the handshake only redirects the exit.
                if (nco_load_ack_i || cnt_q == '0) begin
                    if (!nco_load_ack_i) err_d = 1'b1;
                    state_d = (ral_q && !pend_q && !stop_rise) ? S_RUN : S_IDLE;
                    pend_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (stop_rise) pend_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        clr_d  = (state_d == S_CLR);
        req_d  = (state_d == S_LD_REQ);
        busy_d = (state_d == S_CLR) || (state_d == S_LD_WAIT) || (state_d == S_LD_REQ);
        en_d   = (state_d == S_RUN) ||
                 (((state_d == S_LD_WAIT) || (state_d == S_LD_REQ)) && ral_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            prev_q  <= '0;
            cnt_q   <= '0;
            ral_q   <= 1'b0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            step_q  <= '0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= {load_ready_i, load_start_i, run_stop_i, run_start_i};
            cnt_q   <= cnt_d;
            ral_q   <= ral_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            step_q  <= step_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
        end
    end

    assign nco_en_o        = en_q;
    assign nco_phase_clr_o = clr_q;
    assign nco_step_o      = step_q;
    assign nco_load_req_o  = req_q;
    assign busy_o          = busy_q;
    assign err_o           = err_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_nco_seq_ctrl.sv
// Bench for nco_seq_ctrl: directed scenarios plus random control activity,
// every cycle compared against a behavioural sequencer model.
module tb_nco_seq_ctrl;

    localparam int ACK_TO = 16;
    localparam int SW     = 14;
    localparam int B_START = 0, B_STOP = 1, B_LOAD = 2, B_READY = 3;
    localparam int M_IDLE = 0, M_CLR = 1, M_RUN = 2, M_WAIT = 3, M_REQ = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    ctrl = '0;
    logic [SW-1:0] freq = '0;
    logic          ack = 1'b0;

    logic          en_o, clr_o, req_o, busy_o, err_o;
    logic [SW-1:0] step_o;
    logic [2:0]    state_o;

    int n_vec = 0;
    int n_bad = 0;

    nco_seq_ctrl #(.ACK_TIMEOUT(ACK_TO), .STEP_W(SW)) dut (
        .clk            (clk),
        .rst            (rst),
        .run_start_i    (ctrl[B_START]),
        .run_stop_i     (ctrl[B_STOP]),
        .load_start_i   (ctrl[B_LOAD]),
        .load_ready_i   (ctrl[B_READY]),
        .freq_step_i    (freq),
        .nco_load_ack_i (ack),
        .nco_en_o       (en_o),
        .nco_phase_clr_o(clr_o),
        .nco_step_o     (step_o),
        .nco_load_req_o (req_o),
        .busy_o         (busy_o),
        .err_o          (err_o),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    // behavioural model
    int            mdl_state = M_IDLE;
    bit [3:0]      mdl_prev = '0;
    int            mdl_waited = 0;
    bit            mdl_back_to_run = 0;
    bit            mdl_stop_seen = 0;
    bit            mdl_err = 0;
    bit [SW-1:0]   mdl_step = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit [3:0] r;
        bit finished;
        if (rst) begin
            mdl_state = M_IDLE; mdl_prev = '0; mdl_waited = 0;
            mdl_back_to_run = 0; mdl_stop_seen = 0; mdl_err = 0; mdl_step = '0;
            return;
        end
        r = ctrl & ~mdl_prev;
        mdl_prev = ctrl;
        if (mdl_state == M_IDLE) begin
            if (r[B_START]) mdl_state = M_CLR;
            else if (r[B_LOAD]) begin
                mdl_state = M_WAIT; mdl_back_to_run = 0; mdl_err = 0;
            end
        end else if (mdl_state == M_CLR) begin
            mdl_state = M_RUN;
        end else if (mdl_state == M_RUN) begin
            if (r[B_STOP]) mdl_state = M_IDLE;
            else if (r[B_LOAD]) begin
                mdl_state = M_WAIT; mdl_back_to_run = 1; mdl_err = 0;
            end
        end else if (mdl_state == M_WAIT) begin
            if (r[B_STOP]) mdl_state = M_IDLE;
            else if (r[B_READY]) begin
                mdl_step = freq; mdl_state = M_REQ; mdl_waited = 0; mdl_stop_seen = 0;
            end
        end else begin
            mdl_waited++;
            if (r[B_STOP]) mdl_stop_seen = 1;
            finished = 0;
            if (ack) finished = 1;
            else if (mdl_waited >= ACK_TO) begin
                finished = 1; mdl_err = 1;
            end
            if (finished) mdl_state = (mdl_back_to_run && !mdl_stop_seen) ? M_RUN : M_IDLE;
        end
    endtask

    task automatic tick();
        bit exp_en;
        @(posedge clk);
        model_edge();
        #1;
        exp_en = (mdl_state == M_RUN) ||
                 ((mdl_state == M_WAIT || mdl_state == M_REQ) && mdl_back_to_run);
        chk("state", state_o, mdl_state);
        chk("nco_en", en_o, exp_en);
        chk("phase_clr", clr_o, mdl_state == M_CLR);
        chk("load_req", req_o, mdl_state == M_REQ);
        chk("busy", busy_o, mdl_state == M_CLR || mdl_state == M_WAIT || mdl_state == M_REQ);
        chk("err", err_o, mdl_err);
        chk("step", step_o, mdl_step);
    endtask

    task automatic pulse(input int b);
        ctrl[b] = 1'b1;
        tick();
        ctrl[b] = 1'b0;
    endtask

    initial begin : main
        int nreq;
        bit en_dropped;
        int ack_pct;

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        chk("reset_state", state_o, 0);
        chk("reset_step", step_o, 0);

        // start -> CLR one cycle -> RUN
        pulse(B_START);
        chk("start_clr", clr_o, 1);
        tick();
        chk("start_clr_gone", clr_o, 0);
        chk("start_en", en_o, 1);
        chk("start_run", state_o, 2);
        pulse(B_STOP);
        chk("stop_idle", state_o, 0);

        // load from IDLE, ack on third request cycle
        pulse(B_LOAD);
        freq = 14'h1A5;
        pulse(B_READY);
        nreq = req_o ? 1 : 0;
        tick(); if (req_o) nreq++;
        tick(); if (req_o) nreq++;
        ack = 1'b1;
        tick(); if (req_o) nreq++;
        ack = 1'b0;
        chk("idle_load_req_cycles", nreq, 3);
        chk("idle_load_step", step_o, 14'h1A5);
        chk("idle_load_state", state_o, 0);
        chk("idle_load_en", en_o, 0);

        // load while running, enable must never drop
        pulse(B_START);
        tick();
        en_dropped = 0;
        pulse(B_LOAD);        if (!en_o) en_dropped = 1;
        freq = 14'h3FFF;
        pulse(B_READY);       if (!en_o) en_dropped = 1;
        ack = 1'b1;
        tick();               if (!en_o) en_dropped = 1;
        ack = 1'b0;
        chk("run_load_en_held", en_dropped, 0);
        chk("run_load_state", state_o, 2);
        chk("run_load_step", step_o, 14'h3FFF);

        // ack timeout from RUN
        pulse(B_LOAD);
        freq = 14'h0AB;
        pulse(B_READY);
        nreq = req_o ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (req_o) nreq++;
            else break;
        end
        chk("timeout_req_cycles", nreq, ACK_TO);
        chk("timeout_err", err_o, 1);
        chk("timeout_back_run", state_o, 2);
        pulse(B_LOAD);
        chk("err_cleared_by_load", err_o, 0);

        // stop in LD_WAIT (entered from RUN)
        freq = 14'h1234;
        pulse(B_STOP);
        chk("wait_stop_state", state_o, 0);
        chk("wait_stop_en", en_o, 0);
        chk("wait_stop_step", step_o, 14'h0AB);

        // stop during LD_REQ is deferred to after the ack
        pulse(B_START);
        tick();
        pulse(B_LOAD);
        freq = 14'h2222;
        pulse(B_READY);
        pulse(B_STOP);
        chk("req_stop_deferred", state_o, 4);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("req_stop_after_ack", state_o, 0);

        // reset in the middle of a handshake
        pulse(B_LOAD);
        pulse(B_READY);
        chk("pre_rst_req", req_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_req", req_o, 0);
        chk("rst_step", step_o, 0);
        chk("rst_state", state_o, 0);
        tick();

        // start and stop together in IDLE
        ctrl[B_START] = 1'b1; ctrl[B_STOP] = 1'b1;
        tick();
        ctrl = '0;
        chk("start_stop_idle", state_o, 1);
        tick(); tick();

        // random control activity
        ack_pct = 25;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) ack_pct = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(5, 60);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) ctrl[b] = ~ctrl[b];
            freq = SW'($urandom);
            ack = ($urandom_range(0, 99) < ack_pct);
            rst = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0; ack = 1'b0; ctrl = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/nco_seq_ctrl.md
Name: nco_seq_ctrl

Overview:
Sequencer between the register file's NCO control bits and the NCO core. Edge-detects the software control bits (run start/stop, load start/ready) and runs an FSM. The FSM clears phase, enables the accumulator, and transfers a new 14-bit frequency step through a req/ack handshake. Reports state and a sticky handshake-timeout error back to the register file.

Parameters:
ACK_TIMEOUT, 16, max cycles in LD_REQ without nco_load_ack_i before abort (>=1)
STEP_W, 14, frequency step width

Ports:
clk  input  1  system clock; one clock domain
rst  input  1  reset; one clock; reset is synchronous and active-high
run_start_i  input  1  level from reg file ctrl bit 0; acts on rising edge
run_stop_i  input  1  level from ctrl bit 1; acts on rising edge
load_start_i  input  1  level from ctrl bit 2; acts on rising edge
load_ready_i  input  1  level from ctrl bit 3; rising edge = step bytes consistent
freq_step_i  input  STEP_W  step value from reg file
nco_load_ack_i  input  1  NCO core accepted nco_step_o
nco_en_o  output  1  accumulator enable
nco_phase_clr_o  output  1  one-cycle phase-accumulator clear
nco_step_o  output  STEP_W  step presented to NCO core
nco_load_req_o  output  1  step-load request
busy_o  output  1  FSM in CLR, LD_WAIT or LD_REQ
err_o  output  1  sticky ack-timeout flag
state_o  output  3  FSM state encoding

Behaviour:
- Edge detect: prev registers for the 4 ctrl inputs; rise = in & ~prev. prev resets to 0, so an input high at reset release gives a rise on the first cycle.
- All outputs registered. Reset: state=IDLE, nco_en_o=0, nco_phase_clr_o=0, nco_step_o=0, nco_load_req_o=0, busy_o=0, err_o=0, timeout counter=0, run_after_load=0, shadow step=0.
- State encoding: IDLE=0, CLR=1, RUN=2, LD_WAIT=3, LD_REQ=4.
- IDLE: stop_rise ignored. Else start_rise -> CLR. Else load_rise -> LD_WAIT with run_after_load=0.
- CLR: nco_phase_clr_o=1 for exactly this one cycle; nco_en_o=0; -> RUN next cycle. Edges are ignored here.
- RUN: nco_en_o=1.
  - stop_rise -> IDLE; nco_en_o=0 from the next cycle.
  - Else load_rise -> LD_WAIT with run_after_load=1; nco_en_o stays 1.
  - start_rise in RUN is ignored.
- LD_WAIT: waits for ready_rise.
  - On ready_rise, capture freq_step_i into shadow -> LD_REQ.
  - stop_rise aborts the load -> IDLE, nco_en_o=0; stop beats a simultaneous ready.
  - nco_en_o holds its entry value.
- LD_REQ: nco_load_req_o=1 with the shadow value on nco_step_o; nco_step_o changes only on LD_WAIT->LD_REQ entry.
  - Counter increments each cycle. When nco_load_ack_i=1 on a cycle, drop req next cycle and return to RUN if run_after_load, else IDLE.
  - If the counter reaches ACK_TIMEOUT without ack: drop req, set err_o=1, return as above.
  - Ack and timeout on the same cycle -> ack wins, no error.
  - Stop during LD_REQ is deferred: the req completes first, then the FSM goes to IDLE. A pending stop is latched in a 1-bit flag.
- err_o: cleared on the cycle a load_rise is accepted (IDLE or RUN); otherwise sticky until rst.
- Start and stop rising in the same IDLE cycle -> start taken; in RUN -> stop taken.
- Load and start in the same IDLE cycle -> start taken; the load edge is lost.
- Latency: start rise at cycle N -> phase_clr at N+1 -> nco_en_o=1 from N+2.
- Reset mid-operation (any state, req high) -> all outputs reset values the next cycle; no ack is awaited.

Test Plan:
- Reset, then run_start 0->1 at cycle 5 -> nco_phase_clr_o=1 at cycle 6 only; nco_en_o=1 from cycle 7; state_o=2.
- In IDLE: load_start rise, freq_step_i=14'h1A5, load_ready rise, ack 3 cycles later -> nco_step_o=14'h1A5, req high exactly 3 cycles (LD_REQ entry through ack cycle), then state_o=0, nco_en_o=0.
- In RUN: load with step 14'h3FFF and ack after 1 cycle -> nco_en_o never drops; returns to state_o=2; nco_step_o=14'h3FFF.
- ack tied 0, ACK_TIMEOUT=16 -> req high 16 cycles, then err_o=1 and FSM back to source state. Next load_start rise -> err_o=0.
- run_stop rise while in LD_WAIT from RUN -> state_o=0 next cycle; nco_en_o=0; nco_step_o unchanged. Stop during LD_REQ -> IDLE after the ack.
- rst=1 asserted in LD_REQ -> next cycle nco_load_req_o=0, nco_step_o=0, state_o=0, err_o=0. start and stop rising together in IDLE -> CLR.
